// File: rtl/ex_muldiv_hilo.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Multiplies finish in MUL_CYCLES cycles. Divides use a restoring radix-2
// divider that produces one quotient bit per cycle over 32 iterations.
// HI/LO are written only when an operation completes, or by MTHI/MTLO.
module ex_muldiv_hilo #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pipe2_valid_in,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] vsrc1,
   input  logic [WIDTH-1:0] vsrc2,
   input  logic             pipe2_flush,
   input  logic             pipe3_allow_in,
   output logic             pipe2_allow_in,
   output logic             md_busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
   localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                          OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;

   logic [1:0]       state_q, state_d;
   logic [4:0]       count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;      // raw operands
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic             sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d, dvz_q, dvz_d;

   logic             long_op, is_mul, op_signed;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH:0]   rem_sh, diff;
   logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix;

   assign long_op   = pipe2_valid_in & (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
   assign is_mul    = (md_op == OP_MULT) | (md_op == OP_MULTU);
   assign op_signed = (md_op == OP_MULT) | (md_op == OP_DIV);
   assign a_abs     = (op_signed & vsrc1[WIDTH-1]) ? -vsrc1 : vsrc1;
   assign b_abs     = (op_signed & vsrc2[WIDTH-1]) ? -vsrc2 : vsrc2;

   // Full-width product from the latched operands; the sign extension selects MULT vs MULTU.
   assign ext_a = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
   assign ext_b = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
   assign prod  = ext_a * ext_b;

   // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign rem_n  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_n  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
   assign q_fix  = negq_q ? -quo_n : quo_n;
   assign r_fix  = negr_q ? -rem_n : rem_n;

   // Stall ID/EX while an operation runs; a flush releases the stall immediately.
   always_comb begin
      pipe2_allow_in = 1'b0;
      case (state_q)
         S_IDLE:  pipe2_allow_in = pipe2_flush | (pipe3_allow_in & ~long_op);
         S_MUL,
         S_DIV:   pipe2_allow_in = pipe2_flush;
         default: pipe2_allow_in = pipe3_allow_in;
      endcase
   end

   // Next state: start, iterate, commit. Flush outranks start and completion.
   always_comb begin
      state_d = state_q;  count_d = count_q;
      hi_d    = hi_q;     lo_d    = lo_q;
      opa_d   = opa_q;    opb_d   = opb_q;   sgn_d  = sgn_q;
      quo_d   = quo_q;    rem_d   = rem_q;   dvs_d  = dvs_q;
      negq_d  = negq_q;   negr_d  = negr_q;  dvz_d  = dvz_q;
      case (state_q)
         S_IDLE: begin
            if (pipe2_flush) begin
               state_d = S_IDLE;
            end else if (long_op) begin
               state_d = is_mul ? S_MUL : S_DIV;
               count_d = '0;
               opa_d   = vsrc1;
               opb_d   = vsrc2;
               sgn_d   = op_signed;
               quo_d   = a_abs;
               rem_d   = '0;
               dvs_d   = b_abs;
               negq_d  = op_signed & (vsrc1[WIDTH-1] ^ vsrc2[WIDTH-1]);
               negr_d  = op_signed & vsrc1[WIDTH-1];
               dvz_d   = (vsrc2 == '0);
            end else if (pipe2_valid_in & pipe3_allow_in) begin
               if (md_op == OP_MTHI) hi_d = vsrc1;
               if (md_op == OP_MTLO) lo_d = vsrc1;
            end
         end
         S_MUL: begin
            if (pipe2_flush) begin
               state_d = S_IDLE;
            end else if (count_q == 5'(MUL_CYCLES-1)) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               state_d = S_DONE;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         S_DIV: begin
            if (pipe2_flush) begin
               state_d = S_IDLE;
            end else begin
               quo_d = quo_n;
               rem_d = rem_n;
               if (count_q == 5'(WIDTH-1)) begin
                  // A zero divisor returns all-ones / dividend with no sign fix.
                  hi_d    = dvz_q ? opa_q : r_fix;
                  lo_d    = dvz_q ? '1 : q_fix;
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + 5'd1;
               end
            end
         end
         default: begin
            if (pipe2_flush | pipe3_allow_in) state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation and clears HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;  count_q <= '0;
         hi_q    <= '0;      lo_q    <= '0;
         opa_q   <= '0;      opb_q   <= '0;  sgn_q  <= 1'b0;
         quo_q   <= '0;      rem_q   <= '0;  dvs_q  <= '0;
         negq_q  <= 1'b0;    negr_q  <= 1'b0; dvz_q <= 1'b0;
      end else begin
         state_q <= state_d; count_q <= count_d;
         hi_q    <= hi_d;    lo_q    <= lo_d;
         opa_q   <= opa_d;   opb_q   <= opb_d;  sgn_q  <= sgn_d;
         quo_q   <= quo_d;   rem_q   <= rem_d;  dvs_q  <= dvs_d;
         negq_q  <= negq_d;  negr_q  <= negr_d; dvz_q  <= dvz_d;
      end
   end

   assign md_busy = (state_q != S_IDLE);
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Bench for ex_muldiv_hilo: a vector table of long operations with a
// result scoreboard, followed by hand-written flush/reset/DONE-hold sequences.
module tb_ex_muldiv_hilo;

   localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                          DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

   logic        clk = 1'b0;
   logic        reset, pipe2_valid_in, pipe2_flush, pipe3_allow_in;
   logic [2:0]  md_op;
   logic [31:0] vsrc1, vsrc2;
   logic        pipe2_allow_in, md_busy;
   logic [31:0] hi, lo;

   always #5 clk = ~clk;

   ex_muldiv_hilo #(.WIDTH(32), .MUL_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .pipe2_valid_in(pipe2_valid_in), .md_op(md_op),
      .vsrc1(vsrc1), .vsrc2(vsrc2), .pipe2_flush(pipe2_flush),
      .pipe3_allow_in(pipe3_allow_in), .pipe2_allow_in(pipe2_allow_in),
      .md_busy(md_busy), .hi(hi), .lo(lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, ehi, elo;
      int          lat;   // cycles pipe2_allow_in stays low
   } vec_t;
   typedef struct { logic [31:0] hi, lo; } res_t;

   int   n_cmp = 0, n_bad = 0;
   res_t sb[$];
   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one long op, count stall cycles, compare the committed result at DONE.
   task automatic run_op(input int idx, input vec_t v);
      res_t r;
      int   low = 0;
      bit   done = 0;
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = v.op; vsrc1 = v.a; vsrc2 = v.b;
      sb.push_back('{v.ehi, v.elo});
      for (int c = 0; c < 100; c++) begin
         #1;
         if (!pipe2_allow_in) low++;
         else if (md_busy) begin
            r = sb.pop_front();
            chk($sformatf("vec%0d hi", idx), hi, r.hi);
            chk($sformatf("vec%0d lo", idx), lo, r.lo);
            chk($sformatf("vec%0d stall", idx), low, v.lat);
            done = 1;
            pipe2_valid_in = 1'b0; md_op = 3'b000;
            break;
         end else begin
            chk($sformatf("vec%0d accepted while idle", idx), 1, 0);
            pipe2_valid_in = 1'b0; md_op = 3'b000;
            break;
         end
         @(negedge clk);
      end
      if (!done) begin
         chk($sformatf("vec%0d timeout", idx), 1, 0);
         pipe2_valid_in = 1'b0; md_op = 3'b000;
         void'(sb.pop_front());
      end
      @(negedge clk);
      #1 chk($sformatf("vec%0d back to idle", idx), md_busy, 0);
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] d);
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = op; vsrc1 = d;
      @(negedge clk);
      pipe2_valid_in = 1'b0; md_op = 3'b000;
   endtask

   initial begin
      vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2};
      vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
      vecs[2]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};
      vecs[3]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
      vecs[4]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
      vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
      vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
      vecs[7]  = '{DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 33};
      vecs[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
      vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
      vecs[10] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
      vecs[11] = '{DIVU,  32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 33};
      vecs[12] = '{DIVU,  32'd5,        32'h80000000, 32'h00000005, 32'h00000000, 33};

      reset = 1'b1; pipe2_valid_in = 1'b0; pipe2_flush = 1'b0; pipe3_allow_in = 1'b1;
      md_op = 3'b000; vsrc1 = '0; vsrc2 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset busy", md_busy, 0);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      chk("reset allow", pipe2_allow_in, 1);
      reset = 1'b0;

      foreach (vecs[i]) run_op(i, vecs[i]);

      // MTHI/MTLO, and a flushed MTHI that must not write
      mt(MTHI, 32'hAAAA5555);
      mt(MTLO, 32'h0F0F0F0F);
      #1 chk("mthi", hi, 32'hAAAA5555);
      chk("mtlo", lo, 32'h0F0F0F0F);
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = MTHI; vsrc1 = 32'h11111111; pipe2_flush = 1'b1;
      @(negedge clk);
      pipe2_valid_in = 1'b0; md_op = 3'b000; pipe2_flush = 1'b0;
      #1 chk("flushed mthi", hi, 32'hAAAA5555);

      // Flush beats start in IDLE
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = DIV; vsrc1 = 32'd9; vsrc2 = 32'd2; pipe2_flush = 1'b1;
      #1 chk("flush start allow", pipe2_allow_in, 1);
      @(negedge clk);
      #1 chk("flush start busy", md_busy, 0);
      pipe2_valid_in = 1'b0; md_op = 3'b000; pipe2_flush = 1'b0;

      // Flush beats MUL completion
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = MULTU; vsrc1 = 32'd3; vsrc2 = 32'd3;
      @(negedge clk);
      #1 chk("mul running", md_busy, 1);
      pipe2_flush = 1'b1;
      #1 chk("mul flush allow", pipe2_allow_in, 1);
      @(negedge clk);
      pipe2_valid_in = 1'b0; md_op = 3'b000; pipe2_flush = 1'b0;
      #1 chk("mul flush busy", md_busy, 0);
      chk("mul flush lo", lo, 32'h0F0F0F0F);

      // Flush at DIV iteration 10
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = DIV; vsrc1 = 32'd100; vsrc2 = 32'd3;
      repeat (11) @(negedge clk);
      #1 chk("div it10 busy", md_busy, 1);
      chk("div it10 stalled", pipe2_allow_in, 0);
      pipe2_flush = 1'b1;
      #1 chk("div flush allow", pipe2_allow_in, 1);
      @(negedge clk);
      #1 chk("div flush idle", md_busy, 0);
      pipe2_valid_in = 1'b0; md_op = 3'b000; pipe2_flush = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("div flush hi", hi, 32'hAAAA5555);
      chk("div flush lo", lo, 32'h0F0F0F0F);
      chk("div flush stays idle", md_busy, 0);

      // Reset at DIV iteration 20
      @(negedge clk);
      pipe2_valid_in = 1'b1; md_op = DIVU; vsrc1 = 32'd100; vsrc2 = 32'd3;
      repeat (21) @(negedge clk);
      #1 chk("div it20 busy", md_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; pipe2_valid_in = 1'b0; md_op = 3'b000;
      #1 chk("mid reset busy", md_busy, 0);
      chk("mid reset hi", hi, 0);
      chk("mid reset lo", lo, 0);
      chk("mid reset allow", pipe2_allow_in, 1);

      // DONE held by a stalled EX/MEM, then MTHI once released
      @(negedge clk);
      pipe3_allow_in = 1'b0;
      pipe2_valid_in = 1'b1; md_op = MULT; vsrc1 = 32'd6; vsrc2 = 32'hFFFFFFF9;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("done hold%0d busy", c), md_busy, 1);
         chk($sformatf("done hold%0d allow", c), pipe2_allow_in, 0);
         chk($sformatf("done hold%0d hi", c), hi, 32'hFFFFFFFF);
         chk($sformatf("done hold%0d lo", c), lo, 32'hFFFFFFD6);
         @(negedge clk);
      end
      pipe3_allow_in = 1'b1;
      #1 chk("done release allow", pipe2_allow_in, 1);
      @(negedge clk);
      md_op = MTHI; vsrc1 = 32'h1234ABCD;
      #1 chk("done release idle", md_busy, 0);
      @(negedge clk);
      pipe2_valid_in = 1'b0; md_op = 3'b000;
      #1 chk("mthi after done", hi, 32'h1234ABCD);
      chk("no reissue", md_busy, 0);
      chk("lo kept", lo, 32'hFFFFFFD6);
      chk("scoreboard drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
